// File: rtl/fifo_pop_reader.sv
// Pop-side FIFO consumer: credit-limited POP issue, read-latency absorption, valid/ready output, pop-side flush.
// Optional word counter built when FIFO_POP_READER_WORD_CNT_EN is defined.
//
// state | meaning
// RUN   | normal operation, POP issued when credit and flag allow
// FLUSH | one-cycle Fifo_Pop_Flush pulse, buffer cleared
// DRAIN | RD_LATENCY cycles discarding returning reads
module fifo_pop_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [3:0]            POP_FLAG,
    input  logic [DATA_WIDTH-1:0] DOUT,
    output logic                  POP,
    output logic                  Fifo_Pop_Flush,
    input  logic                  Pop_En,
    input  logic                  Flush_Req,
    output logic                  M_Valid,
    output logic [DATA_WIDTH-1:0] M_Data,
    input  logic                  M_Ready,
    output logic                  Busy,
    output logic [15:0]           Word_Count
);

    localparam int BUF_DEPTH = RD_LATENCY + 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam int CNT_W     = OCC_W + 1;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [OCC_W-1:0]        occ, fl_cnt;
    logic [RD_LATENCY-1:0]   inflight;
    logic [1:0]              drain_cnt;
    logic                    pop_q;
    logic                    credit_ok, flag_ok, capture, xfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (Flush_Req) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'd0) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        POP            = 1'b0;
        Fifo_Pop_Flush = 1'b0;
        Busy           = 1'b0;
        case (state)
            S_RUN:   POP = Reset_n & Pop_En & credit_ok & flag_ok & ~Flush_Req;
            S_FLUSH: begin
                Fifo_Pop_Flush = 1'b1;
                Busy           = 1'b1;
            end
            S_DRAIN: Busy = 1'b1;
            default: Busy = 1'b0;
        endcase
    end

    // POP_FLAG lags one cycle, so a lone word must not be popped twice in a row.
    assign flag_ok   = (POP_FLAG >= 4'h2) | ((POP_FLAG == 4'h1) & ~pop_q);
    assign M_Valid   = (occ != '0) & (state != S_FLUSH);
    assign M_Data    = buf_mem[rd_ptr];
    assign xfer      = M_Valid & M_Ready;
    assign capture   = inflight[RD_LATENCY-1] & (state == S_RUN);
    assign credit_ok = (CNT_W'(occ) + CNT_W'(fl_cnt)) < (CNT_W'(BUF_DEPTH) + CNT_W'(xfer));

    always_comb begin
        fl_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) fl_cnt = fl_cnt + OCC_W'(inflight[i]);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            inflight <= '0;
            pop_q    <= 1'b0;
        end else begin
            inflight[0] <= POP;
            for (int i = 1; i < RD_LATENCY; i++) inflight[i] <= inflight[i-1];
            pop_q <= POP;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            drain_cnt <= 2'd0;
        end else if (state == S_FLUSH) begin
            drain_cnt <= 2'(RD_LATENCY - 1);
        end else if (state == S_DRAIN && drain_cnt != 2'd0) begin
            drain_cnt <= drain_cnt - 2'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
        end else if (state == S_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
        end else begin
            if (capture) begin
                buf_mem[wr_ptr] <= DOUT;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (xfer) rd_ptr <= ptr_inc(rd_ptr);
            case ({capture, xfer})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_POP_READER_WORD_CNT_EN
    logic [15:0] word_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                           word_cnt <= 16'h0000;
        else if (state == S_FLUSH)              word_cnt <= 16'h0000;
        else if (xfer && word_cnt != 16'hFFFF)  word_cnt <= word_cnt + 16'h0001;
    end

    assign Word_Count = word_cnt;
`else
    assign Word_Count = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_pop_reader.sv
// Directed bench for fifo_pop_reader: one instance per read latency, each fed by a small FIFO data model.
module tb_fifo_pop_reader;

`ifdef FIFO_POP_READER_WORD_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  flag1, flag2;
    logic [15:0] dout1, dout2, data1, data2, wc1, wc2;
    logic        pop1, pop2, fl1, fl2, en1, en2, fr1, fr2;
    logic        valid1, valid2, rdy1, rdy2, busy1, busy2;

    fifo_pop_reader #(.DATA_WIDTH(16), .RD_LATENCY(1)) u_l1 (
        .Clk(clk), .Reset_n(rst_n), .POP_FLAG(flag1), .DOUT(dout1), .POP(pop1),
        .Fifo_Pop_Flush(fl1), .Pop_En(en1), .Flush_Req(fr1), .M_Valid(valid1),
        .M_Data(data1), .M_Ready(rdy1), .Busy(busy1), .Word_Count(wc1));

    fifo_pop_reader #(.DATA_WIDTH(16), .RD_LATENCY(2)) u_l2 (
        .Clk(clk), .Reset_n(rst_n), .POP_FLAG(flag2), .DOUT(dout2), .POP(pop2),
        .Fifo_Pop_Flush(fl2), .Pop_En(en2), .Flush_Req(fr2), .M_Valid(valid2),
        .M_Data(data2), .M_Ready(rdy2), .Busy(busy2), .Word_Count(wc2));

    // FIFO data models: the n-th pop returns value n
    logic [15:0] cnt1, cnt2, stage2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= 16'd0; dout1 <= 16'd0;
        end else if (pop1) begin
            cnt1 <= cnt1 + 16'd1; dout1 <= cnt1 + 16'd1;
        end
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt2 <= 16'd0; stage2 <= 16'd0; dout2 <= 16'd0;
        end else begin
            if (pop2) begin
                cnt2 <= cnt2 + 16'd1; stage2 <= cnt2 + 16'd1;
            end
            dout2 <= stage2;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  flag;
        logic        en, fr, rdy;
        logic        pop, valid;
        logic [15:0] data;
        logic        busy, flush;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] flag, input logic en, input logic fr, input logic rdy,
                                input logic pop, input logic valid, input logic [15:0] data,
                                input logic busy, input logic flush);
        vec_t v;
        v.flag = flag; v.en = en; v.fr = fr; v.rdy = rdy;
        v.pop = pop; v.valid = valid; v.data = data; v.busy = busy; v.flush = flush;
        return v;
    endfunction

    vec_t vecs [26];
    logic [16:0] exp_wc;
    int pops, exp_d;

    initial begin
        // stream start, single-word flag, backpressure, flush with read in flight, Pop_En low
        vecs[0]  = mk(4'h2,1,0,1, 1,0,16'd0, 0,0);
        vecs[1]  = mk(4'h2,1,0,1, 1,0,16'd0, 0,0);
        vecs[2]  = mk(4'h2,1,0,1, 1,1,16'd1, 0,0);
        vecs[3]  = mk(4'h2,1,0,1, 1,1,16'd2, 0,0);
        vecs[4]  = mk(4'h2,1,0,1, 1,1,16'd3, 0,0);
        vecs[5]  = mk(4'h1,1,0,1, 0,1,16'd4, 0,0);
        vecs[6]  = mk(4'h1,1,0,1, 1,1,16'd5, 0,0);
        vecs[7]  = mk(4'h1,1,0,1, 0,0,16'd0, 0,0);
        vecs[8]  = mk(4'h0,1,0,1, 0,1,16'd6, 0,0);
        vecs[9]  = mk(4'h2,1,0,0, 1,0,16'd0, 0,0);
        vecs[10] = mk(4'h2,1,0,0, 1,0,16'd0, 0,0);
        vecs[11] = mk(4'h2,1,0,0, 1,1,16'd7, 0,0);
        vecs[12] = mk(4'h2,1,0,0, 0,1,16'd7, 0,0);
        vecs[13] = mk(4'h2,1,0,0, 0,1,16'd7, 0,0);
        vecs[14] = mk(4'h2,1,0,1, 1,1,16'd7, 0,0);
        vecs[15] = mk(4'h2,1,0,1, 1,1,16'd8, 0,0);
        vecs[16] = mk(4'h2,1,0,1, 1,1,16'd9, 0,0);
        vecs[17] = mk(4'h2,1,1,1, 0,1,16'd10,0,0);
        vecs[18] = mk(4'h2,1,1,1, 0,0,16'd0, 1,1);
        vecs[19] = mk(4'h2,1,0,1, 0,0,16'd0, 1,0);
        vecs[20] = mk(4'h2,1,0,1, 1,0,16'd0, 0,0);
        vecs[21] = mk(4'h2,1,0,1, 1,0,16'd0, 0,0);
        vecs[22] = mk(4'h2,1,0,1, 1,1,16'd13,0,0);
        vecs[23] = mk(4'h2,0,0,1, 0,1,16'd14,0,0);
        vecs[24] = mk(4'h2,0,0,1, 0,1,16'd15,0,0);
        vecs[25] = mk(4'h2,0,0,1, 0,0,16'd0, 0,0);

        flag1 = 4'h2; en1 = 1'b1; fr1 = 1'b0; rdy1 = 1'b1;
        flag2 = 4'h3; en2 = 1'b1; fr2 = 1'b0; rdy2 = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pop1", pop1, 0);
        chk("rst_pop2", pop2, 0);
        chk("rst_flush1", fl1, 0);
        chk("rst_valid1", valid1, 0);
        chk("rst_data1", data1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_wc1", wc1, 0);
        chk("rst_valid2", valid2, 0);

        flag1 = 4'h0; flag2 = 4'h0; rdy2 = 1'b0;
        rst_n = 1'b1;
        tick();

        exp_wc = 17'd0;
        for (int i = 0; i < 26; i++) begin
            flag1 = vecs[i].flag; en1 = vecs[i].en; fr1 = vecs[i].fr; rdy1 = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_pop", i), pop1, vecs[i].pop);
            chk($sformatf("v%0d_valid", i), valid1, vecs[i].valid);
            chk($sformatf("v%0d_busy", i), busy1, vecs[i].busy);
            chk($sformatf("v%0d_flush", i), fl1, vecs[i].flush);
            chk($sformatf("v%0d_wc", i), wc1, exp_wc[15:0]);
            if (vecs[i].valid) chk($sformatf("v%0d_data", i), data1, vecs[i].data);
            if (vecs[i].flush) exp_wc = 17'd0;
            else if (CNT_EN && vecs[i].valid && vecs[i].rdy && exp_wc != 17'h0FFFF) exp_wc = exp_wc + 17'd1;
            tick();
        end

        // registered read under backpressure: four pops fill the buffer, head word held
        rdy2 = 1'b0; flag2 = 4'h3; en2 = 1'b1;
        pops = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pop2) pops++;
            if (valid2) chk("bp_hold_data", data2, 16'd1);
            tick();
        end
        chk("bp_pop_count", pops, 4);
        @(negedge clk);
        chk("bp_pop_stopped", pop2, 0);
        chk("bp_valid", valid2, 1);
        tick();

        rdy2 = 1'b1;
        pops = 0;
        exp_d = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pop2) pops++;
            chk("rel_valid", valid2, 1);
            chk("rel_data", data2, exp_d);
            exp_d++;
            tick();
        end
        chk("rel_pop_count", pops, 12);

        // registered-read flush: Busy spans FLUSH plus two DRAIN cycles
        flag2 = 4'h0;
        repeat (8) tick();
        fr2 = 1'b1;
        @(negedge clk);
        chk("f2_req_busy", busy2, 0);
        tick();
        fr2 = 1'b0;
        @(negedge clk);
        chk("f2_flush", fl2, 1);
        chk("f2_busy0", busy2, 1);
        chk("f2_valid", valid2, 0);
        tick();
        @(negedge clk);
        chk("f2_flush_once", fl2, 0);
        chk("f2_busy1", busy2, 1);
        tick();
        @(negedge clk);
        chk("f2_busy2", busy2, 1);
        tick();
        @(negedge clk);
        chk("f2_busy_done", busy2, 0);
        tick();

        // asynchronous reset between clock edges while streaming
        flag1 = 4'h2; en1 = 1'b1; fr1 = 1'b0; rdy1 = 1'b1;
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pop", pop1, 0);
        chk("arst_valid", valid1, 0);
        chk("arst_wc", wc1, 0);
        flag1 = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        flag1 = 4'h2;
        @(negedge clk); chk("post_k0_pop", pop1, 1); chk("post_k0_valid", valid1, 0); tick();
        @(negedge clk); chk("post_k1_pop", pop1, 1); chk("post_k1_valid", valid1, 0); tick();
        @(negedge clk); chk("post_k2_valid", valid1, 1); chk("post_k2_data", data1, 1); tick();
        @(negedge clk); chk("post_k3_data", data1, 2); tick();

        // long run for counter saturation, then flush clears it
        repeat (70000) tick();
        @(negedge clk);
        chk("wc_sat", wc1, CNT_EN ? 16'hFFFF : 16'h0000);
        tick();
        fr1 = 1'b1;
        tick();
        fr1 = 1'b0;
        tick();
        @(negedge clk);
        chk("wc_after_flush", wc1, 0);
        chk("wc_flush_busy", busy1, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
